// File: rtl/plpid_pkg.sv
// Shared encodings for the PLP board-ID probe: bus read/write codes, register
// offsets, FSM states and the bus request bundle.
package plpid_pkg;

    localparam logic [1:0] DRW_IDLE  = 2'b00;
    localparam logic [1:0] DRW_READ  = 2'b10;
    localparam logic [1:0] DRW_WRITE = 2'b01;

    localparam logic [31:0] PLPID_OFS_ID   = 32'd0;
    localparam logic [31:0] PLPID_OFS_FREQ = 32'd4;

    typedef enum logic [2:0] {
        ST_START,
        ST_REQ,
        ST_RD_ID,
        ST_RD_FREQ,
        ST_DONE
    } plpid_state_t;

    typedef struct packed {
        logic        req;
        logic        de;
        logic [31:0] addr;
        logic [1:0]  rw;
    } bus_req_t;

endpackage

// File: rtl/mod_frac_tick.sv
// Fractional divider: emits a one-cycle tick at an average of rate/freq per clock.
module mod_frac_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] freq,
    input  logic [31:0] rate,
    output logic        tick
);

    logic [32:0] acc;
    logic [32:0] acc_n;

    assign acc_n = acc + {1'b0, rate};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (rate >= freq) begin
            // Saturated case: keep acc pinned so it cannot creep toward overflow.
            acc  <= '0;
            tick <= 1'b1;
        end else if (acc_n >= {1'b0, freq}) begin
            acc  <= acc_n - {1'b0, freq};
            tick <= 1'b1;
        end else begin
            acc  <= acc_n;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/mod_plpid_probe.sv
// Reads the board-ID peripheral after reset/rescan and derives a TICK_HZ timebase.
// Optional grant timeout in REQ: define PLPID_PROBE_TIMEOUT_EN.
module mod_plpid_probe
    import plpid_pkg::*;
#(
    parameter logic [31:0] BASE         = 32'h00000000,
    parameter logic [31:0] EXP_ID       = 32'h00000401,
    parameter logic [31:0] DEFAULT_FREQ = 32'h017d7840,
    parameter logic [31:0] TICK_HZ      = 32'd1000000,
    parameter int          READ_LAT     = 2,
    parameter int          GNT_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rescan,
    output logic        req,
    input  logic        gnt,
    output logic        de,
    output logic [31:0] daddr,
    output logic [1:0]  drw,
    output logic [31:0] dwdata,
    input  logic [31:0] drdata,
    output logic [31:0] cpu_id,
    output logic [31:0] board_freq,
    output logic        valid,
    output logic        id_ok,
    output logic        tick
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LAT);

    plpid_state_t state, state_n;
    bus_req_t     bus;
    logic [1:0]   lat;
    logic [31:0]  shadow;
    logic         lat_done;
    logic         probe_ok;
    logic         tmo;

    assign lat_done = (lat == LAT_LAST);
    assign probe_ok = !tmo && (cpu_id == EXP_ID) && (shadow != 32'd0);

`ifdef PLPID_PROBE_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(GNT_TIMEOUT - 1);
    logic [7:0] tcnt;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            ST_START:   state_n = ST_REQ;
            ST_REQ: begin
                if (gnt)
                    state_n = ST_RD_ID;
`ifdef PLPID_PROBE_TIMEOUT_EN
                else if (tcnt == TMO_LAST)
                    state_n = ST_DONE;
`endif
            end
            // Losing the grant mid-read restarts the whole transfer from the ID word.
            ST_RD_ID: begin
                if (!gnt)          state_n = ST_REQ;
                else if (lat_done) state_n = ST_RD_FREQ;
            end
            ST_RD_FREQ: begin
                if (!gnt)          state_n = ST_REQ;
                else if (lat_done) state_n = ST_DONE;
            end
            ST_DONE:    state_n = ST_DONE;
            default:    state_n = ST_START;
        endcase
        if (rescan && state != ST_START)
            state_n = ST_START;
    end

    always_comb begin
        bus = '{req: 1'b0, de: 1'b0, addr: 32'd0, rw: DRW_IDLE};
        case (state)
            ST_REQ:     bus.req = 1'b1;
            ST_RD_ID:   bus = '{req: 1'b1, de: 1'b1, addr: BASE + PLPID_OFS_ID,   rw: DRW_READ};
            ST_RD_FREQ: bus = '{req: 1'b1, de: 1'b1, addr: BASE + PLPID_OFS_FREQ, rw: DRW_READ};
            default:    ;
        endcase
    end

    assign req    = bus.req;
    assign de     = bus.de;
    assign daddr  = bus.addr;
    assign drw    = bus.rw;
    assign dwdata = 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_START;
            lat        <= '0;
            cpu_id     <= '0;
            shadow     <= '0;
            board_freq <= DEFAULT_FREQ;
            valid      <= 1'b0;
            id_ok      <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n == state && (state == ST_RD_ID || state == ST_RD_FREQ))
                lat <= lat + 2'd1;
            else
                lat <= '0;
            if (state == ST_RD_ID && state_n == ST_RD_FREQ)
                cpu_id <= drdata;
            if (state == ST_RD_FREQ && state_n == ST_DONE)
                shadow <= drdata;
`ifdef PLPID_PROBE_TIMEOUT_EN
            if (state == ST_REQ && state_n == ST_DONE)
                cpu_id <= '0;
`endif
            if (state == ST_DONE && state_n == ST_DONE) begin
                valid      <= 1'b1;
                id_ok      <= probe_ok;
                board_freq <= probe_ok ? shadow : DEFAULT_FREQ;
            end
            if (rescan && state != ST_START) begin
                valid <= 1'b0;
                id_ok <= 1'b0;
            end
        end
    end

`ifdef PLPID_PROBE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
            tmo  <= 1'b0;
        end else begin
            tcnt <= (state == ST_REQ && state_n == ST_REQ) ? tcnt + 8'd1 : 8'd0;
            if (state == ST_START)
                tmo <= 1'b0;
            else if (state == ST_REQ && state_n == ST_DONE)
                tmo <= 1'b1;
        end
    end
`endif

    // Restart the divider phase on the first DONE cycle, as the new frequency lands.
    mod_frac_tick u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_DONE && !valid),
        .freq  (board_freq),
        .rate  (TICK_HZ),
        .tick  (tick)
    );

endmodule

// File: tb/tb_mod_plpid_probe.sv
// Directed bench for mod_plpid_probe with a behavioural ID responder.
module tb_mod_plpid_probe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rescan = 1'b0;
    logic        req, gnt, de, valid, id_ok, tick;
    logic [31:0] daddr, dwdata, drdata, cpu_id, board_freq;
    logic [1:0]  drw;
    logic [31:0] id_word, freq_word;

    int checks = 0;
    int failures = 0;
    int n_rd0, n_rd4, n_bad;

    localparam logic [31:0] DEF_FREQ = 32'h017d7840;
    localparam logic [31:0] F3M      = 32'h002DC6C0;

    always #5 clk = ~clk;

    mod_plpid_probe dut (
        .clk(clk), .rst(rst), .rescan(rescan), .req(req), .gnt(gnt), .de(de),
        .daddr(daddr), .drw(drw), .dwdata(dwdata), .drdata(drdata),
        .cpu_id(cpu_id), .board_freq(board_freq), .valid(valid), .id_ok(id_ok),
        .tick(tick)
    );

    assign drdata = !de ? 32'h0 :
                    (daddr == 32'h0) ? id_word :
                    (daddr == 32'h4) ? freq_word : 32'hdeadbeef;

    always @(negedge clk) begin
        if (rst) begin
            n_rd0 = 0; n_rd4 = 0; n_bad = 0;
        end else if (de) begin
            if (daddr == 32'h0) n_rd0++;
            else if (daddr == 32'h4) n_rd4++;
            if (drw !== 2'b10) n_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [31:0] idw, input logic [31:0] fw, input logic g);
        id_word = idw; freq_word = fw; gnt = g; rescan = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, valid, 1'b1);
    endtask

    task automatic tick_period(output int per);
        int n = 0;
        per = -1;
        while (!tick && n < 100) begin @(posedge clk); #1; n++; end
        if (tick) begin
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!tick && n < 100);
            if (tick) per = n;
        end
    endtask

    initial begin
        int per, nt;
        gnt = 1'b1; id_word = 32'h401; freq_word = DEF_FREQ;

        // Reset values while rst held
        repeat (2) @(posedge clk); #1;
        chk("rst_req", req, 1'b0);
        chk("rst_de", de, 1'b0);
        chk("rst_drw", drw, 2'b00);
        chk("rst_daddr", daddr, 32'h0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_id_ok", id_ok, 1'b0);
        chk("rst_cpu_id", cpu_id, 32'h0);
        chk("rst_freq", board_freq, DEF_FREQ);
        chk("rst_tick", tick, 1'b0);

        // Nominal probe: valid exactly at cycle 9
        do_reset(32'h401, DEF_FREQ, 1'b1);
        repeat (8) @(posedge clk); #1;
        chk("t1_valid_c8", valid, 1'b0);
        @(posedge clk); #1;
        chk("t1_valid_c9", valid, 1'b1);
        chk("t1_id_ok", id_ok, 1'b1);
        chk("t1_cpu_id", cpu_id, 32'h401);
        chk("t1_freq", board_freq, DEF_FREQ);
        chk("t1_rd0_cycles", n_rd0, 3);
        chk("t1_rd4_cycles", n_rd4, 3);
        chk("t1_drw_read", n_bad, 0);
        chk("t1_dwdata", dwdata, 32'h0);
        chk("t1_req_done", req, 1'b0);
        tick_period(per); chk("t1_tick_per", per, 25);
        tick_period(per); chk("t1_tick_per2", per, 25);

        // Wrong ID: frequency word ignored, default used
        do_reset(32'h402, F3M, 1'b1);
        wait_valid("t2_valid");
        chk("t2_id_ok", id_ok, 1'b0);
        chk("t2_cpu_id", cpu_id, 32'h402);
        chk("t2_freq", board_freq, DEF_FREQ);

        // Zero frequency word
        do_reset(32'h401, 32'h0, 1'b1);
        wait_valid("t3_valid");
        chk("t3_id_ok", id_ok, 1'b0);
        chk("t3_freq", board_freq, DEF_FREQ);
        tick_period(per); chk("t3_tick_per", per, 25);

        // Grant withheld, then dropped mid-RD_FREQ
        do_reset(32'h401, F3M, 1'b0);
        repeat (10) @(posedge clk); #1;
        chk("t4_req_wait", req, 1'b1);
        chk("t4_de_wait", de, 1'b0);
        gnt = 1'b1;
        nt = 0;
        while (!(de && daddr == 32'h4) && nt < 50) begin @(posedge clk); #1; nt++; end
        chk("t4_in_rdfreq", daddr, 32'h4);
        gnt = 1'b0;
        @(posedge clk); #1;
        chk("t4_req_abort", req, 1'b1);
        chk("t4_de_abort", de, 1'b0);
        gnt = 1'b1;
        @(posedge clk); #1;
        chk("t4_reread_de", de, 1'b1);
        chk("t4_reread_addr", daddr, 32'h0);
        wait_valid("t4_valid");
        chk("t4_id_ok", id_ok, 1'b1);
        chk("t4_cpu_id", cpu_id, 32'h401);
        chk("t4_freq", board_freq, F3M);

        // 3 MHz: 1000 ticks per 3000 cycles, period 3
        tick_period(per); chk("t5_tick_per", per, 3);
        nt = 0;
        repeat (3000) begin @(posedge clk); #1; if (tick) nt++; end
        chk("t5_tick_count", nt, 1000);

        // Rescan from DONE, then again mid-probe
        rescan = 1'b1;
        @(posedge clk); #1;
        rescan = 1'b0;
        chk("t5_rescan_valid", valid, 1'b0);
        chk("t5_rescan_id_ok", id_ok, 1'b0);
        chk("t5_rescan_req", req, 1'b0);
        chk("t5_rescan_freq", board_freq, F3M);
        @(posedge clk); #1;
        chk("t5_restart_req", req, 1'b1);
        repeat (2) @(posedge clk); #1;
        chk("t5_mid_de", de, 1'b1);
        rescan = 1'b1;
        @(posedge clk); #1;
        rescan = 1'b0;
        chk("t5_mid_de_idle", de, 1'b0);
        chk("t5_mid_req_idle", req, 1'b0);
        wait_valid("t5_revalid");
        chk("t5_reid_ok", id_ok, 1'b1);

`ifdef PLPID_PROBE_TIMEOUT_EN
        do_reset(32'h401, F3M, 1'b0);
        nt = 0;
        while (!valid && nt < 400) begin @(posedge clk); #1; nt++; end
        chk("t6_tmo_cycle", nt, 257);
        chk("t6_valid", valid, 1'b1);
        chk("t6_id_ok", id_ok, 1'b0);
        chk("t6_req", req, 1'b0);
        chk("t6_cpu_id", cpu_id, 32'h0);
        chk("t6_freq", board_freq, DEF_FREQ);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
